// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the register_pipe_valid elastic pipeline.
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;
    // Widest data word the parity helper covers; narrower words are zero-extended.
    localparam int PARITY_MAX_W  = 256;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/register_pipe_valid_if.sv
// Valid/ready/data channel; the producer side uses master, the consumer side slave.
interface register_pipe_valid_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: valid flag, data word and (with REG_PIPE_PARITY_EN) a parity bit.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_src_valid,
    input  logic [WIDTH-1:0] i_src_data,
`ifdef REG_PIPE_PARITY_EN
    input  logic             i_src_par,
    output logic             o_par,
`endif
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid/data update; a flush only drops the valid flag, data is left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VALUE;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_src_valid;
            if (i_src_valid) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

`ifdef REG_PIPE_PARITY_EN
    logic r_par;

    // Parity bit travels alongside the data word under the same load rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= even_parity(PARITY_MAX_W'(RESET_VALUE));
        end else if (!i_flush && i_load && i_src_valid) begin
            r_par <= i_src_par;
        end
    end

    assign o_par = r_par;
`endif

endmodule

// File: rtl/register_pipe_valid.sv
// DEPTH-stage elastic valid/ready register pipe with bubble collapsing, flush and occupancy.
// Optional stored-parity checking is enabled by defining REG_PIPE_PARITY_EN.
module register_pipe_valid
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              OCC_W       = occ_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    register_pipe_valid_if.slave  up,
    register_pipe_valid_if.master dn,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  empty,
    output logic                  full
`ifdef REG_PIPE_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_d     [DEPTH];
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

`ifdef REG_PIPE_PARITY_EN
    logic [DEPTH-1:0] w_par;
    logic [DEPTH-1:0] w_src_par;
    logic             r_parity_err;
`endif

    // Ready chain: a stage can load when it is empty or its successor is moving.
    always_comb begin
        w_rdy        = {(DEPTH+1){1'b0}};
        w_rdy[DEPTH] = dn.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_v[i] | w_rdy[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_src_v[i] = up.valid;
            assign w_src_d[i] = up.data;
`ifdef REG_PIPE_PARITY_EN
            assign w_src_par[i] = even_parity(PARITY_MAX_W'(up.data));
`endif
        end else begin : g_body
            assign w_src_v[i] = w_v[i-1];
            assign w_src_d[i] = w_d[i-1];
`ifdef REG_PIPE_PARITY_EN
            assign w_src_par[i] = w_par[i-1];
`endif
        end

        reg_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk         (clk),
            .rst_n       (reset),
            .i_flush     (flush),
            .i_load      (w_rdy[i]),
            .i_src_valid (w_src_v[i]),
            .i_src_data  (w_src_d[i]),
`ifdef REG_PIPE_PARITY_EN
            .i_src_par   (w_src_par[i]),
            .o_par       (w_par[i]),
`endif
            .o_valid     (w_v[i]),
            .o_data      (w_d[i])
        );
    end

    assign up.ready   = w_rdy[0] & ~flush & reset;
    assign dn.valid   = w_v[DEPTH-1] & ~flush;
    assign dn.data    = w_d[DEPTH-1];
    assign w_in_xfer  = up.valid & up.ready;
    assign w_out_xfer = dn.valid & dn.ready;

    // Occupancy tracks accepted-minus-delivered items; flush empties the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ <= {OCC_W{1'b0}};
        end else if (flush) begin
            r_occ <= {OCC_W{1'b0}};
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign occupancy = r_occ;
    assign empty     = (r_occ == {OCC_W{1'b0}});
    assign full      = (r_occ == OCC_W'(DEPTH));

`ifdef REG_PIPE_PARITY_EN
    // Sticky error: only reset clears it, flush deliberately does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else if (w_out_xfer &&
                     (even_parity(PARITY_MAX_W'(dn.data)) != w_par[DEPTH-1])) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_register_pipe_valid.sv
// Directed plus randomized bench for register_pipe_valid (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
module tb_register_pipe_valid;

    localparam int         W   = 8;
    localparam int         D   = 3;
    localparam logic [7:0] RV  = 8'hA5;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    logic       empty;
    logic       full;
`ifdef REG_PIPE_PARITY_EN
    logic       parity_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    register_pipe_valid_if #(.WIDTH(W)) up_if ();
    register_pipe_valid_if #(.WIDTH(W)) dn_if ();

    register_pipe_valid #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .up         (up_if),
        .dn         (dn_if),
        .occupancy  (occupancy),
        .empty      (empty),
`ifdef REG_PIPE_PARITY_EN
        .parity_err (parity_err),
`endif
        .full       (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        up_if.valid = iv;
        up_if.data  = id;
        dn_if.ready = ordy;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mq[$];
    int         cq[$];

    initial begin
        int  cyc;
        bit  iv, ordy, fl, e_ir, e_ov, in_x, out_x;
        logic [7:0] id;

        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_out_valid", dn_if.valid, 32'd0);
        chk("rst_out_data", dn_if.data, 32'(RV));
        chk("rst_in_ready", up_if.ready, 32'd0);
        chk("rst_occ", occupancy, 32'd0);
        chk("rst_empty", empty, 32'd1);
        chk("rst_full", full, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", up_if.ready, 32'd1);
        chk("idle_out_data", dn_if.data, 32'(RV));
        tick();

        // Stream 01..08 with out_ready=1: 3-cycle latency then one per cycle
        for (int t = 0; t < 12; t++) begin
            drive(t < 8, 8'(t + 1), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_in_ready", up_if.ready, 32'd1);
            chk("stream_valid", dn_if.valid, 32'(t >= 3 && t < 11));
            if (t >= 3 && t < 11) chk("stream_data", dn_if.data, 32'(t - 2));
            chk("stream_occ", occupancy, 32'((t < 8 ? t : 8) - (t > 3 ? t - 3 : 0)));
            tick();
        end

        // Fill with out_ready=0, then same-cycle accept when out_ready rises
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 8'(8'h10 + t), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_flag", full, 32'd1);
        chk("full_in_ready", up_if.ready, 32'd0);
        chk("full_out_valid", dn_if.valid, 32'd1);
        chk("full_out_data", dn_if.data, 32'h10);
        chk("full_occ", occupancy, 32'd3);
        dn_if.ready = 1'b1;
        #1;
        chk("full_pass_in_ready", up_if.ready, 32'd1);
        tick();
        chk("full_pass_occ", occupancy, 32'd3);
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            chk("drain_valid", dn_if.valid, 32'(t < 3));
            if (t < 3) chk("drain_data", dn_if.data, 32'(8'h11 + t));
            tick();
        end
        chk("drain_empty", empty, 32'd1);

        // Bubble with out_ready=0 collapses behind the stalled head
        drive(1'b1, 8'h20, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h21, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        @(negedge clk);
        chk("bubble_occ", occupancy, 32'd2);
        chk("bubble_out_valid", dn_if.valid, 32'd1);
        chk("bubble_out_data", dn_if.data, 32'h20);
        chk("bubble_in_ready", up_if.ready, 32'd1);
        chk("bubble_full", full, 32'd0);

        // Flush at occupancy 2 with out_ready=1
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        #1;
        chk("flush_out_valid", dn_if.valid, 32'd0);
        chk("flush_in_ready", up_if.ready, 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_flush_occ", occupancy, 32'd0);
        chk("post_flush_empty", empty, 32'd1);
        chk("post_flush_in_ready", up_if.ready, 32'd1);
        chk("post_flush_out_valid", dn_if.valid, 32'd0);
        tick();
        drive(1'b1, 8'h30, 1'b1, 1'b0);
        tick();
        for (int t = 1; t <= 3; t++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            chk("post_flush_valid", dn_if.valid, 32'(t == 3));
            if (t == 3) chk("post_flush_data", dn_if.data, 32'h30);
            tick();
        end

        // Asynchronous reset mid-stream
        drive(1'b1, 8'h40, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h41, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        @(negedge clk);
        chk("pre_rst_valid", dn_if.valid, 32'd1);
        chk("pre_rst_occ", occupancy, 32'd2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", dn_if.valid, 32'd0);
        chk("async_rst_data", dn_if.data, 32'(RV));
        chk("async_rst_in_ready", up_if.ready, 32'd0);
        chk("async_rst_occ", occupancy, 32'd0);
        chk("async_rst_empty", empty, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Randomized traffic against an age/queue reference model
        cyc = 0;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            id   = 8'($urandom);
            drive(iv, id, ordy, fl);
            @(negedge clk);
            e_ir = !fl && (ordy || mq.size() < D);
            e_ov = 1'b0;
            if (!fl && mq.size() > 0) e_ov = ((cyc - cq[0]) >= D);
            chk("rand_in_ready", up_if.ready, 32'(e_ir));
            chk("rand_out_valid", dn_if.valid, 32'(e_ov));
            if (e_ov) chk("rand_out_data", dn_if.data, 32'(mq[0]));
            chk("rand_occ", occupancy, 32'(mq.size()));
            chk("rand_empty", empty, 32'(mq.size() == 0));
            chk("rand_full", full, 32'(mq.size() == D));
            in_x  = iv && e_ir;
            out_x = e_ov && ordy;
            tick();
            if (fl) begin
                mq.delete();
                cq.delete();
            end else begin
                if (out_x) begin
                    void'(mq.pop_front());
                    void'(cq.pop_front());
                end
                if (in_x) begin
                    mq.push_back(id);
                    cq.push_back(cyc);
                end
            end
            cyc++;
        end

`ifdef REG_PIPE_PARITY_EN
        // Corrupted stored parity must raise a sticky error on delivery
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h3C, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        tick();
        force dut.g_stage[2].u_stage.r_par = 1'b1;
        #1;
        release dut.g_stage[2].u_stage.r_par;
        @(negedge clk);
        chk("par_before", parity_err, 32'd0);
        chk("par_data", dn_if.data, 32'h3C);
        dn_if.ready = 1'b1;
        tick();
        chk("par_set", parity_err, 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk("par_sticky_flush", parity_err, 32'd1);
        reset = 1'b0;
        #1;
        chk("par_reset_clear", parity_err, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
